// File: rtl/pet2001_rx232_pkg.sv
// Shared state encoding, oversampling constants and helpers for the PET 2001 RS-232 receiver.
package pet2001_rx232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned VOTE_LO    = 7;
    localparam int unsigned VOTE_HI    = 9;

    // Rounded clock divisor giving OVERSAMPLE ticks per bit.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud * 8) / (baud * OVERSAMPLE);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pet2001_fifo_sync.sv
// First-word fall-through FIFO; a push while full without a pop is dropped and flagged.
module pet2001_fifo_sync #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overrun
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign empty = (fill == '0);
    assign full  = (fill == (PTR_W + 1)'(DEPTH));
    assign pop   = rd_ready & ~empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !wr_en) begin
                fill <= fill - 1'b1;
            end
            overrun <= push & ~wr_en;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;

endmodule

// File: rtl/pet2001_rx232_fifo.sv
// RS-232 receive front end: 8N1 deserialiser (8E1 when RX232_PARITY_EN is defined),
// byte FIFO and cts232n flow control with hysteresis.
module pet2001_rx232_fifo
    import pet2001_rx232_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 38_400,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned HIWAT  = 12,
    parameter int unsigned LOWAT  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx232,
    output logic                   cts232n,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int unsigned DIV    = baud_div(CLK_HZ, BAUD);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W  = $clog2(OVERSAMPLE);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [SMP_W-1:0] smp_cnt;
    logic [1:0]       votes;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_bad;
    logic             push;
    logic             fall;
    logic             start_det;
    logic             tick;
    logic             vote_evt;
    logic             bit_val;
    logic             push_req;
    logic             ferr_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx232;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign start_det = (state == IDLE) & fall;
    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign vote_evt  = tick & (smp_cnt == SMP_W'(VOTE_HI));
    // Samples VOTE_LO..VOTE_HI-1 are held in votes; the live sample completes the vote.
    assign bit_val   = majority3(votes[1], votes[0], rx_sync);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            votes   <= '1;
        end else if (start_det) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                smp_cnt <= smp_cnt + 1'b1;
                if (smp_cnt >= SMP_W'(VOTE_LO) && smp_cnt < SMP_W'(VOTE_HI)) begin
                    votes <= {votes[0], rx_sync};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (fall) state_next = START;
            START:  if (vote_evt) state_next = bit_val ? IDLE : DATA;
`ifdef RX232_PARITY_EN
            DATA:   if (vote_evt && bit_cnt == 3'd7) state_next = PARITY;
            PARITY: if (vote_evt) state_next = STOP;
`else
            DATA:   if (vote_evt && bit_cnt == 3'd7) state_next = STOP;
`endif
            STOP:   if (vote_evt) state_next = bit_val ? IDLE : BREAK;
            BREAK:  if (rx_sync) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        ferr_req = 1'b0;
        if (state == STOP && vote_evt) begin
            push_req = bit_val & ~par_bad;
            ferr_req = ~bit_val | par_bad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push      <= push_req;
            frame_err <= ferr_req;
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && vote_evt) begin
                shift   <= {bit_val, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef RX232_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
        end else if (state == START) begin
            par_bad <= 1'b0;
        end else if (state == PARITY && vote_evt) begin
            par_bad <= bit_val ^ (^shift);
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    pet2001_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .wr_data  (shift),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .fill     (fill),
        .overrun  (overrun)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts232n <= 1'b1;
        end else if (fill >= FILL_W'(HIWAT)) begin
            cts232n <= 1'b1;
        end else if (fill <= FILL_W'(LOWAT)) begin
            cts232n <= 1'b0;
        end
    end

endmodule
